// File: rtl/spi_sync_fifo_v2_if.sv
// spi_sync_fifo_v2_if: request/status bundle between the bus side (master)
// and the FIFO (slave).
//
// Handshake: wen/ren are single-cycle requests sampled on the rising edge.
// A read is taken when ren=1 and the FIFO is not empty. A write is taken
// when wen=1 and either the FIFO is not full or a read is taken on the same
// edge. A request that is not taken raises the sticky ovf or udf flag. There
// is no back-pressure beyond full/empty, which the master must observe.
interface spi_sync_fifo_v2_if #(
  parameter int DWID   = 8,
  parameter int DDEPTH = 64
);
  localparam int CNTWID = $clog2(DDEPTH);

  logic              fifoen;
  logic              flush;
  logic              wen;
  logic [DWID-1:0]   wdata;
  logic              ren;
  logic [DWID-1:0]   rdata;
  logic              full;
  logic              empty;
  logic              halfway;
  logic              about_full;
  logic              about_empty;
  logic [CNTWID:0]   count;
  logic [CNTWID:0]   afull_lvl;
  logic [CNTWID:0]   aempty_lvl;
  logic              ovf;
  logic              udf;
  logic              clr_err;

  modport master (
    output fifoen, flush, wen, wdata, ren, afull_lvl, aempty_lvl, clr_err,
    input  rdata, full, empty, halfway, about_full, about_empty, count, ovf, udf
  );

  modport slave (
    input  fifoen, flush, wen, wdata, ren, afull_lvl, aempty_lvl, clr_err,
    output rdata, full, empty, halfway, about_full, about_empty, count, ovf, udf
  );
endinterface

// File: rtl/spi_sync_fifo_v2.sv
// spi_sync_fifo_v2: first-word-fall-through synchronous FIFO for the QSPI
// TX/RX paths, with a single-register bypass mode (fifoen=0), occupancy
// count, sticky ovf/udf flags and synchronous flush.
// Optional build macro SPI_FIFO_WATERMARK_EN selects programmable
// almost-full/almost-empty thresholds (afull_lvl/aempty_lvl); without it the
// thresholds are fixed at DDEPTH-1 and 1.
module spi_sync_fifo_v2 #(
  parameter int DWID   = 8,
  parameter int DDEPTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  spi_sync_fifo_v2_if.slave  bus
);
  localparam int CNTWID = $clog2(DDEPTH);
  localparam logic [CNTWID:0] DEPTH_C = (CNTWID+1)'(DDEPTH);
  localparam logic [CNTWID:0] HALF_C  = (CNTWID+1)'(DDEPTH/2);
  localparam logic [CNTWID:0] AFULL_C = (CNTWID+1)'(DDEPTH-1);
  localparam logic [CNTWID:0] ONE_C   = (CNTWID+1)'(1);
  localparam logic [CNTWID:0] ZERO_C  = '0;

  logic [DWID-1:0] mem [DDEPTH];

  logic [CNTWID:0] wptr_q, wptr_d;
  logic [CNTWID:0] rptr_q, rptr_d;
  logic [CNTWID:0] count_q, count_d;
  logic [DWID-1:0] hold_q, hold_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            fifoen_q, fifoen_d;

  logic            clear;
  logic            rd_acc;
  logic            wr_acc;
  logic [CNTWID:0] wr_inc;
  logic [CNTWID:0] rd_dec;

  // Wrap bits and the threshold ports are not needed in every build.
  logic unused_bits;
  assign unused_bits = ^{wptr_q[CNTWID], rptr_q[CNTWID], bus.afull_lvl, bus.aempty_lvl};

  // Next-state: accept rules, pointer/count update, sticky error flags.
  always_comb begin
    // Flush and a mode change both discard contents and suppress requests.
    clear    = bus.flush | (bus.fifoen != fifoen_q);
    rd_acc   = bus.ren & ~empty_q & ~clear;
    wr_acc   = bus.wen & (~full_q | rd_acc) & ~clear;
    wr_inc   = {{CNTWID{1'b0}}, wr_acc};
    rd_dec   = {{CNTWID{1'b0}}, rd_acc};
    fifoen_d = bus.fifoen;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    hold_d   = hold_q;
    count_d  = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      hold_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc && fifoen_q)  wptr_d = wptr_q + ONE_C;
      if (rd_acc && fifoen_q)  rptr_d = rptr_q + ONE_C;
      if (wr_acc && !fifoen_q) hold_d = bus.wdata;
      count_d = count_q + wr_inc - rd_dec;
    end
    full_d  = bus.fifoen ? (count_d == DEPTH_C) : (count_d == ONE_C);
    empty_d = (count_d == ZERO_C);
    // A new error in the clr_err cycle wins over the clear.
    ovf_d = (ovf_q & ~bus.clr_err) | (bus.wen & ~wr_acc & ~clear);
    udf_d = (udf_q & ~bus.clr_err) | (bus.ren & ~rd_acc & ~clear);
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      fifoen_q <= bus.fifoen;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      fifoen_q <= fifoen_d;
    end
  end

  // Storage write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc && fifoen_q) begin
      mem[wptr_q[CNTWID-1:0]] <= bus.wdata;
    end
  end

  // Output decode from registered state (asynchronous read of the head).
  always_comb begin
    bus.full  = full_q;
    bus.empty = empty_q;
    bus.count = count_q;
    bus.ovf   = ovf_q;
    bus.udf   = udf_q;
    if (empty_q)       bus.rdata = '0;
    else if (fifoen_q) bus.rdata = mem[rptr_q[CNTWID-1:0]];
    else               bus.rdata = hold_q;
    if (fifoen_q) begin
      bus.halfway = (count_q >= HALF_C);
`ifdef SPI_FIFO_WATERMARK_EN
      bus.about_full  = (count_q >= bus.afull_lvl);
      bus.about_empty = (count_q <= bus.aempty_lvl);
`else
      bus.about_full  = (count_q >= AFULL_C);
      bus.about_empty = (count_q <= ONE_C);
`endif
    end else begin
      bus.halfway     = full_q;
      bus.about_full  = full_q;
      bus.about_empty = empty_q;
    end
  end
endmodule

// File: tb/tb_spi_sync_fifo_v2.sv
// tb_spi_sync_fifo_v2: directed bench for spi_sync_fifo_v2 (DWID=8, DDEPTH=8).
// Read data goes through an expected queue checked by a negedge monitor;
// status outputs are checked directly after each driven edge.
module tb_spi_sync_fifo_v2;
  localparam int DWID   = 8;
  localparam int DDEPTH = 8;
`ifdef SPI_FIFO_WATERMARK_EN
  localparam int AE_LVL = 2;
  localparam int AF_LVL = 6;
  localparam logic AF_HIGH_LVL_EXP = 1'b0;
`else
  localparam int AE_LVL = 1;
  localparam int AF_LVL = 7;
  localparam logic AF_HIGH_LVL_EXP = 1'b1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [DWID-1:0] exp_q[$];

  spi_sync_fifo_v2_if #(.DWID(DWID), .DDEPTH(DDEPTH)) bus ();

  spi_sync_fifo_v2 #(.DWID(DWID), .DDEPTH(DDEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change at posedge+1, state is checked after the edge
  task automatic step(input logic w, input logic [DWID-1:0] d, input logic r);
    bus.wen = w;
    bus.wdata = d;
    bus.ren = r;
    @(posedge clk);
    #1;
    bus.wen = 1'b0;
    bus.ren = 1'b0;
  endtask

  task automatic wr(input logic [DWID-1:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, '0, 1'b1);
  endtask

  task automatic clr();
    bus.clr_err = 1'b1;
    step(1'b0, '0, 1'b0);
    bus.clr_err = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    step(1'b0, '0, 1'b0);
    bus.flush = 1'b0;
  endtask

  // Scoreboard monitor: every accepted read pops one expected word
  always @(negedge clk) begin
    if (!rst && !bus.flush && bus.ren && !bus.empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected actual=%0h expected=none", bus.rdata);
      end else begin
        logic [DWID-1:0] e;
        e = exp_q.pop_front();
        if (bus.rdata !== e) begin
          errors++;
          $display("FAIL rd_data actual=%0h expected=%0h", bus.rdata, e);
        end
      end
    end
  end

  initial begin
    logic [DWID-1:0] dv;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.fifoen = 1'b1;
    bus.flush = 1'b0;
    bus.wen = 1'b0;
    bus.wdata = '0;
    bus.ren = 1'b0;
    bus.clr_err = 1'b0;
    bus.afull_lvl = 4'd6;
    bus.aempty_lvl = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_halfway", bus.halfway, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_about_empty", bus.about_empty, 1);
    check("rst_about_full", bus.about_full, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_udf", bus.udf, 0);
    rst = 1'b0;

    // Fill / drain with overflow and underflow
    for (int i = 1; i <= 8; i++) begin
      wr(DWID'(i));
      exp_q.push_back(DWID'(i));
      if (i == 1) check("first_wr_rdata", bus.rdata, 8'h01);
    end
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 8);
    check("fill_halfway", bus.halfway, 1);
    check("fill_ovf_pre", bus.ovf, 0);
    wr(8'hFF);
    check("ovf_set", bus.ovf, 1);
    check("ovf_count", bus.count, 8);
    for (int i = 0; i < 8; i++) rd();
    check("drain_empty", bus.empty, 1);
    check("drain_rdata", bus.rdata, 0);
    check("drain_count", bus.count, 0);
    check("drain_udf_pre", bus.udf, 0);
    rd();
    check("udf_set", bus.udf, 1);
    clr();
    check("clr_ovf", bus.ovf, 0);
    check("clr_udf", bus.udf, 0);

    // Simultaneous read/write at full and at empty
    for (int i = 0; i < 8; i++) begin
      wr(8'h10 + DWID'(i));
      exp_q.push_back(8'h10 + DWID'(i));
    end
    exp_q.push_back(8'hAA);
    step(1'b1, 8'hAA, 1'b1);
    check("full_rw_count", bus.count, 8);
    check("full_rw_full", bus.full, 1);
    check("full_rw_ovf", bus.ovf, 0);
    for (int i = 0; i < 8; i++) rd();
    step(1'b1, 8'h55, 1'b1);
    check("empty_rw_udf", bus.udf, 1);
    check("empty_rw_count", bus.count, 1);
    check("empty_rw_rdata", bus.rdata, 8'h55);
    exp_q.push_back(8'h55);
    rd();
    clr();

    // Wrap-around: 20 rounds of write-3 / read-3
    dv = 8'h80;
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < 3; j++) begin
        wr(dv);
        exp_q.push_back(dv);
        dv++;
        check("wrap_wr_count", bus.count, j + 1);
      end
      for (int j = 0; j < 3; j++) begin
        rd();
        check("wrap_rd_count", bus.count, 2 - j);
      end
    end
    check("wrap_ovf", bus.ovf, 0);
    check("wrap_udf", bus.udf, 0);

    // Flush: contents dropped, requests ignored, flags untouched
    for (int i = 0; i < 5; i++) wr(8'hC0 + DWID'(i));
    bus.flush = 1'b1;
    step(1'b1, 8'hCF, 1'b1);
    bus.flush = 1'b0;
    check("flush_count", bus.count, 0);
    check("flush_empty", bus.empty, 1);
    check("flush_ovf", bus.ovf, 0);
    bus.flush = 1'b1;
    step(1'b0, '0, 1'b1);
    bus.flush = 1'b0;
    check("flush_no_udf", bus.udf, 0);
    rd();
    do_flush();
    check("flush_keeps_udf", bus.udf, 1);
    clr();

    // Mode switch to bypass
    wr(8'hD0);
    wr(8'hD1);
    bus.fifoen = 1'b0;
    step(1'b0, '0, 1'b0);
    check("mode_count", bus.count, 0);
    check("mode_empty", bus.empty, 1);
    wr(8'h3C);
    check("byp_full", bus.full, 1);
    check("byp_count", bus.count, 1);
    check("byp_rdata", bus.rdata, 8'h3C);
    check("byp_halfway", bus.halfway, 1);
    check("byp_about_full", bus.about_full, 1);
    check("byp_about_empty", bus.about_empty, 0);
    wr(8'h3D);
    check("byp_ovf", bus.ovf, 1);
    check("byp_rdata_kept", bus.rdata, 8'h3C);
    exp_q.push_back(8'h3C);
    rd();
    check("byp_empty_rdata", bus.rdata, 0);
    wr(8'h41);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    step(1'b1, 8'h42, 1'b1);
    check("byp_rw_count", bus.count, 1);
    rd();
    bus.fifoen = 1'b1;
    step(1'b0, '0, 1'b0);
    check("back_fifo_count", bus.count, 0);
    check("mode_keeps_ovf", bus.ovf, 1);
    clr();

    // Watermarks and halfway while filling
    for (int k = 1; k <= 7; k++) begin
      wr(8'hE0 + DWID'(k));
      check("wm_about_empty", bus.about_empty, (k <= AE_LVL) ? 1 : 0);
      check("wm_about_full", bus.about_full, (k >= AF_LVL) ? 1 : 0);
      check("wm_halfway", bus.halfway, (k >= 4) ? 1 : 0);
    end
    bus.afull_lvl = 4'd9;
    wr(8'hE8);
    check("wm_high_lvl", bus.about_full, AF_HIGH_LVL_EXP);
    bus.afull_lvl = 4'd6;
    do_flush();

    // Reset in the middle of a stream
    for (int i = 0; i < 8; i++) begin
      wr(8'h60 + DWID'(i));
      exp_q.push_back(8'h60 + DWID'(i));
    end
    wr(8'hEE);
    for (int i = 0; i < 4; i++) rd();
    check("pre_rst_count", bus.count, 4);
    check("pre_rst_ovf", bus.ovf, 1);
    exp_q.delete();
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b0);
    rst = 1'b0;
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_empty", bus.empty, 1);
    check("mid_rst_ovf", bus.ovf, 0);
    check("mid_rst_rdata", bus.rdata, 0);
    wr(8'h99);
    check("post_rst_rdata", bus.rdata, 8'h99);
    exp_q.push_back(8'h99);
    rd();
    check("post_rst_empty", bus.empty, 1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_sync_fifo_v2.md
Name: spi_sync_fifo_v2

Overview:
- Next-generation synchronous FIFO for the flex QSPI TX/RX data paths.
- Parametrised width and power-of-two depth, first-word-fall-through read, occupancy count, sticky overflow/underflow flags, synchronous flush.
- Keeps the single-register bypass mode (fifoen=0) for non-FIFO SPI transfers.
- Sits between the register/bus interface and the QSPI shift engine, one per direction.

Parameters:
- DWID, 8, data width in bits (>=1).
- DDEPTH, 64, entries; power of two, >=4. CNTWID = $clog2(DDEPTH).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- fifoen  input  1  1 = FIFO mode (DDEPTH entries); 0 = single-register bypass.
- flush  input  1  synchronous clear of contents and count.
- wen  input  1  write request.
- wdata  input  DWID  write data.
- ren  input  1  read/pop request.
- rdata  output  DWID  head-of-queue data (FWFT).
- full  output  1  no free entry.
- empty  output  1  no valid entry.
- halfway  output  1  count >= DDEPTH/2.
- about_full  output  1  almost-full watermark.
- about_empty  output  1  almost-empty watermark.
- count  output  CNTWID+1  current occupancy, 0..DDEPTH.
- afull_lvl  input  CNTWID+1  almost-full threshold; used only with SPI_FIFO_WATERMARK_EN.
- aempty_lvl  input  CNTWID+1  almost-empty threshold; used only with SPI_FIFO_WATERMARK_EN.
- ovf  output  1  sticky: write rejected.
- udf  output  1  sticky: read rejected.
- clr_err  input  1  clears ovf/udf.

Behaviour:
- Reset (rst=1 at edge):
  - Pointers, count and the bypass holding register are cleared; ovf=udf=0.
  - Outputs: empty=1, full=0, count=0, halfway=0, rdata=0.
  - about_empty=1; about_full=0 unless its threshold is 0.
  - Storage array is not reset.
- Storage: distributed RAM, synchronous write, asynchronous read. Pointers are CNTWID+1 bits with a wrap bit; index = low CNTWID bits. Wrap past DDEPTH-1 to 0 is seamless.
- Accept rules, evaluated each edge:
  - rd_acc = ren & !empty.
  - wr_acc = wen & (!full | rd_acc).
  - A write while full is accepted only when a read is accepted in the same cycle; count is unchanged.
  - Read while empty is rejected even if wen=1; the write is still accepted.
- count_next = count + wr_acc - rd_acc. full, empty and count are registered and update on the same edge.
- Latency:
  - Write accepted at edge N: empty falls after edge N; rdata shows that word in cycle N+1.
  - Read accepted at edge N: rdata advances to the next word after edge N.
- rdata = mem[rptr] when !empty, else 0. It is deterministic for the verifier.
- halfway is a combinational level from the registered count (not a pulse).
- ovf set on any edge with wen & !wr_acc; udf set on ren & !rd_acc.
  - clr_err clears both; a new error in the same cycle as clr_err wins (flag stays 1).
  - Flags are cleared only by rst or clr_err, not by flush.
- flush=1:
  - Pointers, count and holding register are cleared next edge; wen/ren that cycle are ignored and raise no errors.
  - Priority: rst > flush > wen/ren.
- Bypass (fifoen=0):
  - One holding register; count is 0 or 1; full = !empty.
  - wen accepted when empty, or when full together with an accepted ren (same rules as above).
  - rdata = holding register when full, else 0.
  - halfway = full.
- Mode change: any edge where fifoen differs from its registered previous value acts as an implicit flush. Contents are discarded and flags preserved.
- Watermarks without the macro: about_full = count >= DDEPTH-1; about_empty = count <= 1.
- Watermarks in bypass mode: about_full = full and about_empty = empty, regardless of macro.

Optional Feature:
- Macro SPI_FIFO_WATERMARK_EN.
- Defined:
  - about_full = (count >= afull_lvl); about_empty = (count <= aempty_lvl).
  - Thresholds are sampled combinationally and may change at any time.
  - afull_lvl > DDEPTH gives about_full=0 permanently.
- Undefined: fixed thresholds as in Behaviour. afull_lvl/aempty_lvl ports remain present but are ignored, so instantiations are identical in both builds.

Test Plan:
- Fill/drain (DWID=8, DDEPTH=8): write 0x01..0x08, then 9th write 0xFF -> full=1 after 8th edge, count=8, ovf=1 after 9th, 0xFF not stored. Read 8 -> rdata sequence 0x01..0x08, empty=1, rdata=0. 9th read -> udf=1.
- Simultaneous at boundaries: full with wen=ren=1 (wdata 0xAA) -> count stays 8, 0xAA emerges last. Empty with wen=ren=1 (0x55) -> write accepted, read rejected, udf=1, count=1, rdata=0x55 next cycle.
- Wrap-around: 20 rounds of write-3/read-3 on DDEPTH=8 with incrementing data -> read data strictly matches write order, count never exceeds 3, no flags.
- Flush and mode switch: load 5 words, assert flush with wen=1 -> count=0, empty=1, ovf unchanged. Load 2, toggle fifoen to 0 -> count=0. In bypass, write 0x3C, write 0x3D -> full=1, rdata=0x3C, ovf=1.
- Watermarks (macro defined): afull_lvl=6, aempty_lvl=2, write 6 words -> about_empty drops on the 3rd write, about_full rises on the 6th, halfway rises on the 4th. Rebuild without the macro -> about_full at count=7, about_empty deasserts at count=2.
- Reset mid-operation: rst during a stream with count=4 and ovf=1 -> next cycle count=0, empty=1, ovf=0, rdata=0; next write is read back correctly.
